// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: FIFO entry layout, instruction widths and the
// RV32 base opcodes that the Controller decodes.
package fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 7;
    // Entries carry a full 32-bit PC; narrower PCs are zero-extended.
    localparam int PC_MAX_W = 32;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

    localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_S    = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_B    = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR = 7'b1100111;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPCODE_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register-based FIFO of fetched {pc, instr} entries. Overflow is
// prevented upstream by the issue credit rule, so none is checked here.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       push_data,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_reg] <= push_data;
    end

    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-fetch stage: owns the PC, issues credit-limited sequential
// memory requests, buffers responses and hands {pc, instr} to decode.
module ifetch_buffer
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    input  logic                 halt,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [INSTR_W-1:0]   inst,
    output logic [OPCODE_W-1:0]  inst_opcode,
    output logic [PC_W-1:0]      inst_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [PC_W-1:0]  resp_pc_reg, resp_pc_next;
    logic [CNT_W-1:0] outstanding_reg, outstanding_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic             run_reg;
    logic [CNT_W-1:0] count;
    logic [PC_W-1:0]  redirect_target;
    logic             credit_ok, issue, resp, push, pop;
    fetch_entry_t     push_data, head;

    // Buffered plus in-flight words never exceed the FIFO size.
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding_reg}) < (CNT_W + 1)'(DEPTH);
    assign imem_req  = run_reg && !halt && !redirect_valid && credit_ok;
    assign imem_addr = fetch_pc_reg;
    assign issue     = imem_req && imem_ready;

    // Responses with nothing outstanding (e.g. stale ones across a reset) are ignored.
    assign resp = imem_rvalid && (outstanding_reg != '0);
    assign push = resp && (drop_cnt_reg == '0) && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    assign redirect_target = redirect_pc & ~PC_W'(3);
    assign push_data       = '{pc: PC_MAX_W'(resp_pc_reg), instr: imem_rdata};

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        drop_cnt_next    = drop_cnt_reg;
        outstanding_next = outstanding_reg + CNT_W'(issue) - CNT_W'(resp);
        if (redirect_valid) begin
            fetch_pc_next = redirect_target;
            resp_pc_next  = redirect_target;
            // Everything still in flight after this cycle's response is stale.
            drop_cnt_next = outstanding_reg - CNT_W'(resp);
        end else begin
            if (issue) fetch_pc_next = fetch_pc_reg + PC_W'(4);
            if (push)  resp_pc_next  = resp_pc_reg + PC_W'(4);
            if (resp && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            run_reg         <= 1'b0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            run_reg         <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_data),
        .count     (count),
        .head      (head)
    );

    assign inst_valid  = (count != '0);
    assign inst        = head.instr;
    assign inst_opcode = opcode_of(head.instr);
    assign inst_pc     = head.pc[PC_W-1:0];

endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized bench for ifetch_buffer: an in-order memory model with stale
// tagging predicts the issued addresses and the delivered instruction stream.
module tb_ifetch_buffer;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit PC instance (random + directed)
    logic        a_reset, a_req, a_ready, a_rvalid, a_redir, a_halt, a_ivalid, a_iready;
    logic [31:0] a_addr, a_rdata, a_redir_pc, a_inst, a_ipc;
    logic [6:0]  a_op;

    // 8-bit PC instance (wrap and reset directed)
    logic        b_reset, b_req, b_ready, b_rvalid, b_redir, b_halt, b_ivalid, b_iready;
    logic [7:0]  b_addr, b_redir_pc, b_ipc;
    logic [31:0] b_rdata, b_inst;
    logic [6:0]  b_op;

    ifetch_buffer dut_a (
        .clk(clk), .reset(a_reset), .imem_req(a_req), .imem_addr(a_addr),
        .imem_ready(a_ready), .imem_rvalid(a_rvalid), .imem_rdata(a_rdata),
        .redirect_valid(a_redir), .redirect_pc(a_redir_pc), .halt(a_halt),
        .inst_valid(a_ivalid), .inst_ready(a_iready), .inst(a_inst),
        .inst_opcode(a_op), .inst_pc(a_ipc)
    );

    ifetch_buffer #(.PC_W(8), .RESET_PC(8'hFC), .DEPTH(2)) dut_b (
        .clk(clk), .reset(b_reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ready(b_ready), .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
        .redirect_valid(b_redir), .redirect_pc(b_redir_pc), .halt(b_halt),
        .inst_valid(b_ivalid), .inst_ready(b_iready), .inst(b_inst),
        .inst_opcode(b_op), .inst_pc(b_ipc)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h00B50533;
        return {addr[15:0] ^ 16'hA5C3, addr[31:16]} ^ (addr * 32'h9E3779B1);
    endfunction

    // Reference model state
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       memq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          buffered = 0;
    logic [31:0] exp_pc = 0;
    logic [31:0] exp_fetch = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_inst = 0;

    // Knobs driven by the scenario code
    bit          halt_v = 0, redir_v = 0, iready_v = 1, mready_v = 1, redir_on_rsp_pop = 0;
    bit          rsp_pop_hit = 0;
    logic [31:0] redir_pc_v = 0;
    int          lat_min = 1, lat_max = 1;
    int          fires = 0, pops = 0;

    task automatic reset_a();
        @(negedge clk);
        a_reset = 1'b0;
        a_halt = 0; a_redir = 0; a_iready = 1; a_ready = 1; a_rvalid = 0;
        repeat (2) @(negedge clk);
        a_reset = 1'b1;
        a_rvalid = 1'b1;            // late response with nothing outstanding
        a_rdata = $urandom;
        #1;
        check_eq("req_after_reset", a_req, 0);
        check_eq("valid_after_reset", a_ivalid, 0);
        memq.delete();
        buffered = 0;
        exp_pc = 0;
        exp_fetch = 0;
        prev_hold = 0;
        last_due = cyc;
    endtask

    task automatic step();
        bit          rsp, redir, exp_req, do_pop;
        mreq_t       front;
        logic [31:0] w;
        int          due;
        @(negedge clk);
        rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        a_rvalid = rsp;
        a_rdata  = rsp ? mem_word(memq[0].addr) : $urandom;
        a_halt   = halt_v;
        a_iready = iready_v;
        a_ready  = mready_v;
        redir    = redir_v || (redir_on_rsp_pop && rsp && buffered > 0 && iready_v);
        if (redir_on_rsp_pop && redir) rsp_pop_hit = 1;
        a_redir    = redir;
        a_redir_pc = redir ? redir_pc_v : $urandom;
        #1;
        exp_req = !halt_v && !redir && (buffered + memq.size() < DEPTH);
        check_eq("imem_req", a_req, exp_req);
        if (a_req) check_eq("imem_addr", a_addr, exp_fetch);
        check_eq("inst_valid", a_ivalid, buffered > 0);
        if (buffered > 0) begin
            w = mem_word(exp_pc);
            check_eq("inst_pc", a_ipc, exp_pc);
            check_eq("inst", a_inst, w);
            check_eq("inst_opcode", a_op, w[6:0]);
            if (exp_pc == 32'h0) check_eq("opcode_r_type", a_op, 7'b0110011);
        end
        if (prev_hold) check_eq("inst_hold", a_inst, prev_inst);
        prev_hold = (buffered > 0) && !iready_v && !redir;
        prev_inst = a_inst;

        // Advance the model across the coming rising edge
        do_pop = (buffered > 0) && iready_v && !redir;
        if (do_pop) begin
            buffered--;
            exp_pc += 4;
            pops++;
        end
        if (rsp) begin
            front = memq.pop_front();
            if (!front.stale && !redir) buffered++;
        end
        if (redir) begin
            foreach (memq[i]) memq[i].stale = 1;
            buffered  = 0;
            exp_pc    = redir_pc_v & ~32'h3;
            exp_fetch = redir_pc_v & ~32'h3;
        end
        if (exp_req && mready_v) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: exp_fetch, due: due, stale: 0});
            exp_fetch += 4;
            fires++;
        end
        cyc++;
    endtask

    int f0;

    initial begin
        a_reset = 0; a_ready = 1; a_rvalid = 0; a_rdata = 0; a_redir = 0;
        a_redir_pc = 0; a_halt = 0; a_iready = 1;
        b_reset = 0; b_ready = 1; b_rvalid = 0; b_rdata = 0; b_redir = 0;
        b_redir_pc = 0; b_halt = 0; b_iready = 1;

        // 8-bit PC: wrap past 0xFC and reset mid-stream
        repeat (2) @(negedge clk);
        b_reset = 1;
        #1;
        check_eq("b_req_after_reset", b_req, 0);
        @(negedge clk); #1;
        check_eq("b_req_first", b_req, 1);
        check_eq("b_addr_first", b_addr, 8'hFC);
        @(negedge clk);
        b_rvalid = 1; b_rdata = 32'h11;
        #1;
        check_eq("b_addr_wrap", b_addr, 8'h00);
        @(negedge clk);
        b_rvalid = 1; b_rdata = 32'h22;
        #1;
        check_eq("b_inst_pc_fc", b_ipc, 8'hFC);
        check_eq("b_inst_fc", b_inst, 32'h11);
        @(negedge clk);
        b_reset = 0; b_rvalid = 0;
        @(negedge clk);
        @(negedge clk);
        b_reset = 1; b_rvalid = 1; b_rdata = 32'h33;
        #1;
        check_eq("b_req_after_midreset", b_req, 0);
        check_eq("b_valid_after_midreset", b_ivalid, 0);
        @(negedge clk);
        b_rvalid = 0;
        #1;
        check_eq("b_late_rvalid_ignored", b_ivalid, 0);
        check_eq("b_addr_restart", b_addr, 8'hFC);
        @(negedge clk);
        b_rvalid = 1; b_rdata = 32'h44;
        @(negedge clk);
        b_rvalid = 0;
        #1;
        check_eq("b_valid_restart", b_ivalid, 1);
        check_eq("b_inst_pc_restart", b_ipc, 8'hFC);
        check_eq("b_inst_restart", b_inst, 32'h44);

        // 32-bit PC: basic streaming from reset
        reset_a();
        pops = 0;
        repeat (10) step();
        check_eq("stream_pops", pops >= 3, 1);

        // Decode stalled: issue stops at DEPTH credits, head stays put
        iready_v = 0;
        f0 = fires;
        repeat (10) step();
        check_eq("stall_fires_bounded", (fires - f0) <= DEPTH, 1);
        check_eq("stall_req_off", a_req, 0);
        iready_v = 1;
        repeat (6) step();

        // Redirect with two long-latency requests in flight
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && memq.size() != 2; i++) step();
        check_eq("redir_two_outstanding", memq.size(), 2);
        redir_v = 1; redir_pc_v = 32'h41;
        step();
        redir_v = 0;
        for (int i = 0; i < 20 && !a_ivalid; i++) step();
        check_eq("redir_first_inst_pc", a_ipc, 32'h40);
        repeat (6) step();

        // Redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 2;
        redir_pc_v = 32'h100;
        redir_on_rsp_pop = 1;
        for (int i = 0; i < 40 && !rsp_pop_hit; i++) step();
        redir_on_rsp_pop = 0;
        check_eq("rsp_pop_redirect_hit", rsp_pop_hit, 1);
        step();
        check_eq("rsp_pop_redirect_empty", a_ivalid, 0);
        repeat (6) step();

        // halt with one request outstanding
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20 && memq.size() != 1; i++) step();
        check_eq("halt_one_outstanding", memq.size(), 1);
        halt_v = 1;
        f0 = fires;
        repeat (8) step();
        check_eq("halt_no_fires", fires - f0, 0);
        halt_v = 0;
        repeat (8) step();

        // Randomized traffic with an occasional mid-stream reset
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                lat_min = 1;
                lat_max = $urandom_range(1, 4);
            end
            if (n == 1500) reset_a();
            halt_v     = ($urandom_range(0, 9) == 0);
            redir_v    = ($urandom_range(0, 24) == 0);
            redir_pc_v = $urandom;
            iready_v   = ($urandom_range(0, 3) != 0);
            mready_v   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
Instruction-fetch stage sitting directly upstream of the decode/Controller stage. It owns the PC, issues sequential requests to instruction memory over a ready/valid interface, and buffers returned words in a small FIFO. It presents {pc, instr, opcode} to decode with a valid/ready handshake. Branch/jump redirects from the execute stage flush the buffer and discard in-flight responses.

Parameters:
PC_W, 32, byte-address width of the PC; wraps modulo 2^PC_W.
RESET_PC, 0, fetch address after reset; bits [1:0] must be 0.
DEPTH, 2, FIFO entries; also the maximum outstanding memory requests (power of 2, >= 2).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset (reset == 0 resets on the next rising clk edge).
imem_req  out  1  request valid.
imem_addr  out  PC_W  word-aligned request byte address.
imem_ready  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response valid; responses return in request order, latency >= 1.
imem_rdata  in  32  instruction word.
redirect_valid  in  1  taken branch / jal / jalr.
redirect_pc  in  PC_W  redirect target.
halt  in  1  stop issuing new requests while high.
inst_valid  out  1  head FIFO entry valid.
inst_ready  in  1  decode consumes the entry.
inst  out  32  head instruction.
inst_opcode  out  7  inst[6:0], driven to the Controller Opcode input.
inst_pc  out  PC_W  PC of the head instruction.

Behaviour:
- Reset:
  - fetch_pc = resp_pc = RESET_PC.
  - FIFO count, outstanding and drop_cnt = 0.
  - imem_req = 0 and inst_valid = 0 in the cycle after reset.
  - Reset mid-operation abandons everything. Any rvalid while outstanding == 0 is ignored.
- Issue:
  - imem_req = !halt && !redirect_valid && (count + outstanding < DEPTH). This credit rule guarantees a push never overflows.
  - imem_addr = fetch_pc.
  - On imem_req && imem_ready: fetch_pc += 4 (wraps) and outstanding += 1.
  - imem_req may deassert without a handshake; imem_addr is held stable only while imem_req && !imem_ready.
- Response (imem_rvalid):
  - outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and discard the word.
  - Otherwise push {resp_pc, imem_rdata} and resp_pc += 4.
- Pop on inst_valid && inst_ready. Push and pop in the same cycle are legal, and count is unchanged.
- A response can enter the FIFO and be seen by decode one cycle after rvalid at the earliest. There is no combinational path from imem_rdata to inst.
- inst, inst_pc and inst_opcode hold stable while inst_valid && !inst_ready.
- Redirect has highest priority:
  - Flush the FIFO (count = 0, pointers reset). inst_valid = 0 next cycle, and no pop is counted that cycle.
  - fetch_pc = resp_pc = {redirect_pc[PC_W-1:2], 2'b00}.
  - drop_cnt = outstanding after accounting for this cycle's issue (none) and this cycle's response. A same-cycle response is discarded.
  - Issuing from the new PC resumes the next cycle.
- halt:
  - Blocks issue only; in-flight responses and FIFO drain normally.
  - Deasserting halt resumes from fetch_pc.
- FIFO pointers wrap modulo DEPTH. count ranges 0..DEPTH. Full (count == DEPTH) implies imem_req = 0.

Decomposition:
- fetch_pkg:
  - INSTR_W = 32 and OPCODE_W = 7.
  - fetch_entry_t packed struct {pc, instr}.
  - Opcode constants (R/I/S/B/LOAD/JAL/JALR) shared with the Controller.
- Sub-module fetch_fifo (DEPTH entries of fetch_entry_t):
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - No overflow checking; this is guaranteed by the credit rule above.

Test Plan:
- Reset low 2 cycles then high, imem_ready = 1, fixed 1-cycle latency, inst_ready = 1 -> first imem_addr = 0x0. inst_pc sequence 0x0, 0x4, 0x8. inst_opcode = 7'b0110011 for word 0x00B50533.
- inst_ready = 0 held 10 cycles -> at most DEPTH = 2 requests issued, then imem_req = 0. inst = first word, stable. On release, both words delivered in order with no loss.
- 3-cycle latency with 2 outstanding, redirect_valid to 0x41 -> both stale responses dropped. Next imem_addr = 0x40 and first inst_pc = 0x40.
- Redirect in the same cycle as rvalid and a pop -> response dropped, FIFO empty next cycle, no underflow, count = 0.
- halt = 1 with 1 outstanding -> no new imem_req. Pending instruction is still delivered. halt = 0 resumes at the next sequential PC.
- PC_W = 8, RESET_PC = 0xFC -> second request address wraps to 0x00. Reset asserted mid-stream -> the next request is at 0xFC and late rvalid is ignored.
